// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the integer and FP write ports between the
// in-order writeback pipe and a FIFO of long-latency results, with starvation and WAW handling.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4,
    parameter int DATA_W     = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pipe_valid,
    input  logic                            pipe_fp,
    input  logic [4:0]                      pipe_rd,
    input  logic [DATA_W-1:0]               pipe_data,
    output logic                            pipe_stall,
    input  logic                            lng_valid,
    output logic                            lng_ready,
    input  logic                            lng_fp,
    input  logic [4:0]                      lng_rd,
    input  logic [DATA_W-1:0]               lng_data,
    input  logic                            halted,
    output logic                            reg_we,
    output logic [4:0]                      reg_wnum,
    output logic [DATA_W-1:0]               reg_wdata,
    output logic                            freg_we,
    output logic [4:0]                      freg_wnum,
    output logic [DATA_W-1:0]               freg_wdata,
    output logic [$clog2(FIFO_DEPTH):0]     pending_cnt,
    output logic                            drained
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [FIFO_DEPTH-1:0] q_fp;
    logic [FIFO_DEPTH-1:0] q_killed;
    logic [4:0]            q_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [SW-1:0]         starve_cnt;
    logic [SW-1:0]         starve_next;

    logic              h_vld, h_live, h_fp, h_killed;
    logic [4:0]        h_rd;
    logic [DATA_W-1:0] h_data;
    logic              push, pop, grant_h, grant_p, stall;
    logic              int_we, fp_we;
    logic [4:0]        int_num, fp_num;
    logic [DATA_W-1:0] int_data, fp_data;

    assign h_vld    = (pending_cnt != '0);
    assign h_fp     = q_fp[rd_ptr];
    assign h_killed = q_killed[rd_ptr];
    assign h_rd     = q_rd[rd_ptr];
    assign h_data   = q_data[rd_ptr];
    // A killed head is dropped without taking a port, so pipe sees an empty FIFO.
    assign h_live   = h_vld && !h_killed;

    assign lng_ready  = (pending_cnt < CW'(FIFO_DEPTH)) && !halted;
    assign push       = lng_valid && lng_ready;
    assign pop        = h_vld && (h_killed || grant_h);
    assign pipe_stall = stall;

    always_comb begin
        grant_h     = 1'b0;
        grant_p     = 1'b0;
        stall       = 1'b0;
        starve_next = '0;
        if (h_live && pipe_valid) begin
            if (h_fp != pipe_fp) begin
                grant_h = 1'b1;
                grant_p = 1'b1;
            end else if (starve_cnt < SW'(STARVE_MAX)) begin
                grant_p     = 1'b1;
                starve_next = starve_cnt + 1'b1;
            end else begin
                grant_h = 1'b1;
                stall   = 1'b1;
            end
        end else begin
            grant_h = h_live;
            grant_p = pipe_valid;
        end
    end

    always_comb begin
        int_we   = 1'b0;
        int_num  = '0;
        int_data = '0;
        fp_we    = 1'b0;
        fp_num   = '0;
        fp_data  = '0;
        if (grant_h) begin
            if (h_fp) begin
                fp_we   = 1'b1;
                fp_num  = h_rd;
                fp_data = h_data;
            end else begin
                int_we   = 1'b1;
                int_num  = h_rd;
                int_data = h_data;
            end
        end
        if (grant_p) begin
            if (pipe_fp) begin
                fp_we   = 1'b1;
                fp_num  = pipe_rd;
                fp_data = pipe_data;
            end else begin
                int_we   = 1'b1;
                int_num  = pipe_rd;
                int_data = pipe_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_fp        <= '0;
            q_killed    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_rd[i]   <= '0;
                q_data[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pending_cnt <= '0;
            starve_cnt  <= '0;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (grant_p && (q_fp[i] == pipe_fp) && (q_rd[i] == pipe_rd))
                    q_killed[i] <= 1'b1;
            end
            // Push comes after the kill loop so a same-cycle accept takes its own kill flag.
            if (push) begin
                q_fp[wr_ptr]     <= lng_fp;
                q_rd[wr_ptr]     <= lng_rd;
                q_data[wr_ptr]   <= lng_data;
                q_killed[wr_ptr] <= grant_p && (lng_fp == pipe_fp) && (lng_rd == pipe_rd);
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            pending_cnt <= pending_cnt + CW'(push) - CW'(pop);
            starve_cnt  <= starve_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_we     <= 1'b0;
            reg_wnum   <= '0;
            reg_wdata  <= '0;
            freg_we    <= 1'b0;
            freg_wnum  <= '0;
            freg_wdata <= '0;
            drained    <= 1'b0;
        end else begin
            reg_we  <= int_we && (int_num != 5'd0);
            freg_we <= fp_we;
            if (int_we) begin
                reg_wnum  <= int_num;
                reg_wdata <= int_data;
            end
            if (fp_we) begin
                freg_wnum  <= fp_num;
                freg_wdata <= fp_data;
            end
            drained <= halted && (pending_cnt == '0);
        end
    end

endmodule
